// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch stage of the single-issue RV32 NPC core.
//   Owns the PC, issues exactly one word read per instruction over a
//   valid/ready imem port and presents {inst, pc} to decode over a
//   valid/ready handshake. A redirect (branch/jump/trap) flushes any
//   in-flight or held fetch and reloads the PC.
//
//   Sequence per instruction: REQ -> WAIT -> HOLD (no overlap), so the
//   best case is one instruction every three cycles.
//
// Parameters
//   XLEN            PC/address/instruction width
//   RESET_PC        PC loaded on reset
//
// Ports
//   clk             in   1     rising-edge clock
//   rst_n           in   1     asynchronous active-low reset
//   imem_req_valid  out  1     read request valid
//   imem_req_ready  in   1     memory accepts request
//   imem_req_addr   out  XLEN  word address of request (= pc)
//   imem_rsp_valid  in   1     read data valid (1-cycle pulse, always accepted)
//   imem_rsp_data   in   XLEN  read data
//   out_valid       out  1     {out_inst,out_pc} valid to decode
//   out_ready       in   1     decode accepts
//   out_inst        out  XLEN  fetched instruction word
//   out_pc          out  XLEN  PC of out_inst
//   redirect_valid  in   1     flush + load new PC (1-cycle pulse)
//   redirect_pc     in   XLEN  new PC; bits [1:0] forced to zero
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction memory request
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    // instruction memory response
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    // decode interface
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    // redirect from execute / trap logic
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;  // one cycle after reset release
    localparam logic [1:0] ST_REQ  = 2'd1;  // presenting a request to imem
    localparam logic [1:0] ST_WAIT = 2'd2;  // request accepted, awaiting data
    localparam logic [1:0] ST_HOLD = 2'd3;  // instruction held for decode

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]      state,    state_nxt;
    logic [XLEN-1:0] pc,       pc_nxt;
    logic            kill,     kill_nxt;   // outstanding rsp must be dropped
    logic            load_out;             // capture rsp into output regs

    logic            req_fire;
    logic            out_fire;
    logic [XLEN-1:0] redirect_target;

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    // A redirect in REQ suppresses the request in the same cycle so that the
    // stale PC never reaches memory.
    assign imem_req_valid = (state == ST_REQ) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign out_valid      = (state == ST_HOLD);

    assign req_fire        = imem_req_valid && imem_req_ready;
    // A redirect in HOLD discards the held word, so it is not a handshake.
    assign out_fire        = out_valid && out_ready && !redirect_valid;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        load_out  = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end

            ST_REQ: begin
                if (req_fire) begin
                    state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    // The outstanding response has arrived; the kill flag
                    // has done its job whether or not the data is used.
                    kill_nxt = 1'b0;
                    if (!kill && !redirect_valid) begin
                        load_out  = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end else if (redirect_valid) begin
                    // Memory still owes us a word; remember to drop it.
                    kill_nxt = 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    state_nxt = ST_REQ;
                end else if (out_fire) begin
                    pc_nxt    = pc + PC_STEP;   // wraps modulo 2^XLEN
                    state_nxt = ST_REQ;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Redirect has the highest priority on the PC in every state.
        if (redirect_valid) begin
            pc_nxt = redirect_target;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
        end
    end

    // Output holding registers: only loaded from an accepted response, so
    // they stay stable for the whole time out_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_inst <= '0;
            out_pc   <= RESET_PC;
        end else if (load_out) begin
            out_inst <= imem_rsp_data;
            out_pc   <= pc;
        end
    end

endmodule
